// File: rtl/decode_pkg.sv
// Shared defaults, control-bundle bit positions and the ID/EX bundle layout for the decode stage.
package decode_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_CNT    = 8;
  localparam int DEF_SIG_W      = 41;
  localparam int DEF_IN_SEL_BIT = 18;
  localparam int DEF_MEM_RD_BIT = 12;

  // ID/EX boundary contents at the default widths.
  typedef struct packed {
    logic                          valid;
    logic [DEF_SIG_W-1:0]          ctrl;
    logic [DEF_DATA_W-1:0]         rd1;
    logic [DEF_DATA_W-1:0]         rd2;
    logic [$clog2(DEF_REG_CNT)-1:0] rsrc1;
    logic [$clog2(DEF_REG_CNT)-1:0] rsrc2;
    logic [$clog2(DEF_REG_CNT)-1:0] rdst;
  } idex_t;

endpackage

// File: rtl/decode_stage_p_reg_file.sv
// 2-read/1-write register file with asynchronous clear and same-cycle write-through to both read ports.
module reg_file_p #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int REG_AW  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [REG_CNT];

  // NOTE: the array is cleared on reset because software relies on all-zero registers;
  // a generic RAM would normally skip this so it can map onto memory macros.
  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: each output gets its array value first so no path leaves it unassigned (no latch).
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: register-file read with bypass, IN-port capture, hazard detection and the ID/EX register.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_CNT    = DEF_REG_CNT,
  parameter int REG_AW     = $clog2(REG_CNT),
  parameter int SIG_W      = DEF_SIG_W,
  parameter int IN_SEL_BIT = DEF_IN_SEL_BIT,
  parameter int MEM_RD_BIT = DEF_MEM_RD_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid_i,
  input  logic [SIG_W-1:0]  ctrl_i,
  input  logic [REG_AW-1:0] rsrc1_i,
  input  logic [REG_AW-1:0] rsrc2_i,
  input  logic [REG_AW-1:0] rdst_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [DATA_W-1:0] in_port_i,
  input  logic              in_strobe_i,
  output logic              in_ready_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hold_o,
  output logic              ex_valid_o,
  output logic [SIG_W-1:0]  ex_ctrl_o,
  output logic [DATA_W-1:0] ex_rd1_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [REG_AW-1:0] ex_rsrc1_o,
  output logic [REG_AW-1:0] ex_rsrc2_o,
  output logic [REG_AW-1:0] ex_rdst_o
);

  typedef struct packed {
    logic              valid;
    logic [SIG_W-1:0]  ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [REG_AW-1:0] rsrc1;
    logic [REG_AW-1:0] rsrc2;
    logic [REG_AW-1:0] rdst;
  } ex_bundle_t;

  ex_bundle_t        ex_q, ex_d;
  logic [DATA_W-1:0] read1, read2;
  logic [DATA_W-1:0] in_reg;
  logic              in_pending;
  logic              load_use, in_wait, advance, in_consume;

  reg_file_p #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .REG_AW(REG_AW)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en_i),
    .waddr  (wb_addr_i),
    .wdata  (wb_data_i),
    .raddr1 (rsrc1_i),
    .raddr2 (rsrc2_i),
    .rdata1 (read1),
    .rdata2 (read2)
  );

  assign load_use = id_valid_i & ex_q.valid & ex_q.ctrl[MEM_RD_BIT]
                  & ((ex_q.rdst == rsrc1_i) | (ex_q.rdst == rsrc2_i));
  assign in_wait  = id_valid_i & ctrl_i[IN_SEL_BIT] & ~in_pending;
  assign hold_o   = load_use | in_wait;

  // An IN instruction only leaves decode on a true advance, which is when its captured word is used up.
  assign advance    = ~flush_i & ~stall_i & ~hold_o;
  assign in_consume = advance & id_valid_i & ctrl_i[IN_SEL_BIT];

  assign ex_d.valid = id_valid_i;
  assign ex_d.ctrl  = id_valid_i ? ctrl_i : '0;
  assign ex_d.rd1   = ctrl_i[IN_SEL_BIT] ? in_reg : read1;
  assign ex_d.rd2   = read2;
  assign ex_d.rsrc1 = rsrc1_i;
  assign ex_d.rsrc2 = rsrc2_i;
  assign ex_d.rdst  = rdst_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg     <= '0;
      in_pending <= 1'b0;
    end else if (in_consume) begin
      in_pending <= 1'b0;
    end else if (in_strobe_i && !in_pending) begin
      in_reg     <= in_port_i;
      in_pending <= 1'b1;
    end
  end

  // Flush and hold both insert an all-zero bubble; stall simply keeps the current contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ex_q <= '0;
    else if (flush_i)  ex_q <= '0;
    else if (!stall_i) ex_q <= hold_o ? '0 : ex_d;
  end

  assign in_ready_o = ~in_pending;
  assign ex_valid_o = ex_q.valid;
  assign ex_ctrl_o  = ex_q.ctrl;
  assign ex_rd1_o   = ex_q.rd1;
  assign ex_rd2_o   = ex_q.rd2;
  assign ex_rsrc1_o = ex_q.rsrc1;
  assign ex_rsrc2_o = ex_q.rsrc2;
  assign ex_rdst_o  = ex_q.rdst;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: default 16-bit instance plus a 32-bit x 16-register instance.
module tb_decode_stage_p;

  localparam logic [40:0] C_MEM_RD = 41'h1 << 12;
  localparam logic [40:0] C_IN_SEL = 41'h1 << 18;
  localparam logic [40:0] C_ALU    = 41'h100_0000_0003;

  logic clk, rst;
  int   vectors, miscompares;

  // Default instance signals
  logic        id_valid, wb_en, in_strobe, stall, flush;
  logic [40:0] ctrl;
  logic [2:0]  rsrc1, rsrc2, rdst, wb_addr;
  logic [15:0] wb_data, in_port;
  logic        in_ready, hold, ex_valid;
  logic [40:0] ex_ctrl;
  logic [15:0] ex_rd1, ex_rd2;
  logic [2:0]  ex_rsrc1, ex_rsrc2, ex_rdst;

  // Wide instance signals
  logic        w_id_valid, w_wb_en;
  logic [3:0]  w_rsrc2, w_wb_addr;
  logic [31:0] w_wb_data;
  logic        w_in_ready, w_hold, w_ex_valid;
  logic [40:0] w_ex_ctrl;
  logic [31:0] w_ex_rd1, w_ex_rd2;
  logic [3:0]  w_ex_rsrc1, w_ex_rsrc2, w_ex_rdst;

  decode_stage_p dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .ctrl_i(ctrl),
    .rsrc1_i(rsrc1), .rsrc2_i(rsrc2), .rdst_i(rdst),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .in_port_i(in_port), .in_strobe_i(in_strobe), .in_ready_o(in_ready),
    .stall_i(stall), .flush_i(flush), .hold_o(hold),
    .ex_valid_o(ex_valid), .ex_ctrl_o(ex_ctrl), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2),
    .ex_rsrc1_o(ex_rsrc1), .ex_rsrc2_o(ex_rsrc2), .ex_rdst_o(ex_rdst)
  );

  decode_stage_p #(.DATA_W(32), .REG_CNT(16), .REG_AW(4)) dut_w (
    .clk(clk), .rst(rst), .id_valid_i(w_id_valid), .ctrl_i(41'h0),
    .rsrc1_i(4'h0), .rsrc2_i(w_rsrc2), .rdst_i(4'h1),
    .wb_en_i(w_wb_en), .wb_addr_i(w_wb_addr), .wb_data_i(w_wb_data),
    .in_port_i(32'h0), .in_strobe_i(1'b0), .in_ready_o(w_in_ready),
    .stall_i(1'b0), .flush_i(1'b0), .hold_o(w_hold),
    .ex_valid_o(w_ex_valid), .ex_ctrl_o(w_ex_ctrl), .ex_rd1_o(w_ex_rd1), .ex_rd2_o(w_ex_rd2),
    .ex_rsrc1_o(w_ex_rsrc1), .ex_rsrc2_o(w_ex_rsrc2), .ex_rdst_o(w_ex_rdst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0;
    id_valid = 0; ctrl = '0; rsrc1 = 0; rsrc2 = 0; rdst = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; in_port = 0; in_strobe = 0; stall = 0; flush = 0;
    w_id_valid = 0; w_wb_en = 0; w_rsrc2 = 0; w_wb_addr = 0; w_wb_data = 0;

    // Reset state
    #2;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_ctrl", ex_ctrl, 41'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_hold", hold, 1'b0);
    step(); step();
    #2 rst = 1'b1;

    // Wide instance: write r15, then read it back through rsrc2
    w_wb_en = 1; w_wb_addr = 4'd15; w_wb_data = 32'h1234_5678;
    step();
    w_wb_en = 0; w_rsrc2 = 4'd15; w_id_valid = 1;
    step();
    check("wide_ex_valid", w_ex_valid, 1'b1);
    check("wide_ex_rd2", w_ex_rd2, 32'h1234_5678);
    w_id_valid = 0;

    // Write-back bypass into operand 1
    id_valid = 1; ctrl = '0; rsrc1 = 3'd3; rsrc2 = 3'd0; rdst = 3'd5;
    wb_en = 1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    step();
    check("byp_ex_valid", ex_valid, 1'b1);
    check("byp_ex_rd1", ex_rd1, 16'hBEEF);
    check("byp_ex_rdst", ex_rdst, 3'd5);
    check("byp_ex_rsrc1", ex_rsrc1, 3'd3);
    wb_en = 0; rsrc1 = 3'd0; rsrc2 = 3'd3;
    step();
    check("rf_stored_rd2", ex_rd2, 16'hBEEF);

    // Load-use: load to r2 (also writing r2 = 2222), then a consumer of r2
    ctrl = C_MEM_RD; rsrc1 = 0; rsrc2 = 0; rdst = 3'd2;
    wb_en = 1; wb_addr = 3'd2; wb_data = 16'h2222;
    #1 check("lu_no_hold_pre", hold, 1'b0);
    step();
    check("lu_load_ctrl", ex_ctrl, C_MEM_RD);
    wb_en = 0; ctrl = '0; rsrc1 = 3'd1; rsrc2 = 3'd2; rdst = 3'd4;
    #1 check("lu_hold", hold, 1'b1);
    step();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_ctrl", ex_ctrl, 41'h0);
    check("lu_hold_released", hold, 1'b0);
    step();
    check("lu_issue_valid", ex_valid, 1'b1);
    check("lu_issue_rdst", ex_rdst, 3'd4);
    check("lu_issue_rd2", ex_rd2, 16'h2222);

    // IN wait, then strobe 00A5
    ctrl = C_IN_SEL; rsrc1 = 0; rsrc2 = 0; rdst = 3'd6;
    #1 check("in_wait_hold", hold, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("in_wait_bubble", ex_valid, 1'b0);
      check("in_wait_hold_cyc", hold, 1'b1);
    end
    in_port = 16'h00A5; in_strobe = 1;
    step();
    in_strobe = 0;
    #1;
    check("in_cap_ready", in_ready, 1'b0);
    check("in_cap_hold", hold, 1'b0);
    check("in_cap_ex_valid", ex_valid, 1'b0);
    step();
    check("in_issue_valid", ex_valid, 1'b1);
    check("in_issue_rd1", ex_rd1, 16'h00A5);
    check("in_issue_ctrl", ex_ctrl, C_IN_SEL);
    check("in_issue_ready", in_ready, 1'b1);
    id_valid = 0; ctrl = '0;

    // Strobe while pending is dropped
    in_port = 16'h0011; in_strobe = 1;
    step();
    in_port = 16'h0022;
    step();
    in_strobe = 0; id_valid = 1; ctrl = C_IN_SEL;
    #1 check("in_pend_hold", hold, 1'b0);
    step();
    check("in_drop_rd1", ex_rd1, 16'h0011);
    check("in_drop_ready", in_ready, 1'b1);
    id_valid = 0; ctrl = '0;

    // Stall holds, flush beats stall
    id_valid = 1; ctrl = C_ALU; rsrc1 = 3'd3; rsrc2 = 3'd2; rdst = 3'd7;
    step();
    check("fs_ex_ctrl", ex_ctrl, C_ALU);
    check("fs_ex_rd1", ex_rd1, 16'hBEEF);
    check("fs_ex_rd2", ex_rd2, 16'h2222);
    stall = 1; ctrl = 41'h5; rsrc1 = 3'd5; rdst = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", ex_valid, 1'b1);
      check("stall_ctrl", ex_ctrl, C_ALU);
      check("stall_rd1", ex_rd1, 16'hBEEF);
      check("stall_rdst", ex_rdst, 3'd7);
    end
    flush = 1;
    step();
    check("flush_valid", ex_valid, 1'b0);
    check("flush_ctrl", ex_ctrl, 41'h0);
    flush = 0; stall = 0;

    // Asynchronous reset mid-run
    ctrl = '0; rsrc1 = 3'd3; rsrc2 = 3'd2; rdst = 3'd4;
    in_port = 16'h0077; in_strobe = 1;
    step();
    in_strobe = 0;
    check("pre_rst_valid", ex_valid, 1'b1);
    check("pre_rst_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_valid", ex_valid, 1'b0);
    check("arst_rd1", ex_rd1, 16'h0);
    check("arst_rdst", ex_rdst, 3'd0);
    check("arst_ready", in_ready, 1'b1);
    #1 rst = 1'b1;
    step();
    check("arst_rf_cleared", ex_rd1, 16'h0);
    check("arst_rf_cleared2", ex_rd2, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
